// File: rtl/sum_accum.sv
// Frame accumulator: sums COUNT unsigned samples, then holds the total until the consumer takes it.
// Latency: out_valid rises 1 cycle after the COUNT-th accepted sample; in_ready is low while holding.
// Optional macro SUM_ACCUM_SAT_EN: clamp the accumulator to all ones on overflow instead of wrapping.
module sum_accum #(
    parameter int WIDTH     = 4,
    parameter int ACC_WIDTH = 16,
    parameter int COUNT     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH:0]       sum_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovf,
    output logic [7:0]           smp_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] COUNT_C = 8'(COUNT);

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           cnt_q, cnt_d;

    logic                 accept;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH:0]   add_full;
    logic [7:0]           cnt_inc;

    // One spare bit above the accumulator catches the carry that flags overflow.
    assign sum_ext  = {{(ACC_WIDTH - WIDTH){1'b0}}, sum_in};
    assign add_full = {1'b0, acc_q} + sum_ext;
    assign cnt_inc  = cnt_q + 8'd1;

    assign in_ready  = (state_q != HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;
    assign smp_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = sum_ext[ACC_WIDTH-1:0];
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (add_full[ACC_WIDTH]) begin
                        ovf_d = 1'b1;
                    end
`ifdef SUM_ACCUM_SAT_EN
                    // Once saturated, stay pinned for the rest of the frame.
                    if (add_full[ACC_WIDTH] || ovf_q) begin
                        acc_d = '1;
                    end else begin
                        acc_d = add_full[ACC_WIDTH-1:0];
                    end
`else
                    acc_d = add_full[ACC_WIDTH-1:0];
`endif
                    if (cnt_inc == COUNT_C) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ovf_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sum_accum.sv
// Randomised bench for sum_accum: two instances (16-bit acc / 8 samples, 8-bit acc / 9 samples),
// checked against a frame-level arithmetic model.
module tb_sum_accum;

    logic        clk;
    logic        rst;
    logic [4:0]  sum_in;
    logic        in_valid;
    logic        out_ready;
    logic        sel;

    logic        in_valid0, in_valid1, out_ready0, out_ready1;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [15:0] acc0;
    logic [7:0]  acc1;
    logic [7:0]  cnt0, cnt1;

    logic [31:0] acc_m;
    logic        in_ready_m, out_valid_m, ovf_m;
    logic [7:0]  cnt_m;

    int          errors = 0;
    int          checks = 0;
    int unsigned smp[$];

    assign in_valid0  = in_valid  & ~sel;
    assign in_valid1  = in_valid  &  sel;
    assign out_ready0 = out_ready & ~sel;
    assign out_ready1 = out_ready &  sel;

    assign acc_m       = sel ? 32'(acc1) : 32'(acc0);
    assign in_ready_m  = sel ? in_ready1  : in_ready0;
    assign out_valid_m = sel ? out_valid1 : out_valid0;
    assign ovf_m       = sel ? ovf1 : ovf0;
    assign cnt_m       = sel ? cnt1 : cnt0;

    sum_accum #(.WIDTH(4), .ACC_WIDTH(16), .COUNT(8)) u_dut0 (
        .clk(clk), .rst(rst), .sum_in(sum_in), .in_valid(in_valid0), .in_ready(in_ready0),
        .acc_out(acc0), .out_valid(out_valid0), .out_ready(out_ready0), .ovf(ovf0), .smp_cnt(cnt0)
    );

    sum_accum #(.WIDTH(4), .ACC_WIDTH(8), .COUNT(9)) u_dut1 (
        .clk(clk), .rst(rst), .sum_in(sum_in), .in_valid(in_valid1), .in_ready(in_ready1),
        .acc_out(acc1), .out_valid(out_valid1), .out_ready(out_ready1), .ovf(ovf1), .smp_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Frame result from plain arithmetic on the whole sample list.
    function automatic longint exp_acc(input longint total, input int aw);
        longint lim;
        lim = longint'(1) << aw;
        if (total < lim) return total;
`ifdef SUM_ACCUM_SAT_EN
        return lim - 1;
`else
        return total % lim;
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        chk_eq("rst_acc0", 32'(acc0), 0);
        chk_eq("rst_acc1", 32'(acc1), 0);
        chk_eq("rst_ovld", {30'd0, out_valid0, out_valid1}, 0);
        chk_eq("rst_ovf",  {30'd0, ovf0, ovf1}, 0);
        chk_eq("rst_cnt",  {16'd0, cnt0, cnt1}, 0);
        chk_eq("rst_rdy",  {30'd0, in_ready0, in_ready1}, 3);
    endtask

    task automatic send(input int unsigned s);
        in_valid = 1'b1; sum_in = 5'(s);
        tick();
        in_valid = 1'b0;
    endtask

    // Plays smp[] as one frame on the selected instance, holds the result, then hands it off.
    task automatic run_frame(input int gapmax, input int hold_cyc);
        int     n;
        int     aw;
        longint total;
        longint e_acc;
        bit     e_ovf;
        n = sel ? 9 : 8;
        aw = sel ? 8 : 16;
        total = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gapmax)) begin
                in_valid = 1'b0; sum_in = 5'($urandom); out_ready = 1'($urandom);
                tick();
                chk_eq("gap_ovld", 32'(out_valid_m), 0);
                chk_eq("gap_cnt", 32'(cnt_m), 32'(i));
            end
            out_ready = 1'($urandom);
            chk_eq("acc_rdy", 32'(in_ready_m), 1);
            send(smp[i]);
            out_ready = 1'b0;
            total += longint'(smp[i]);
            chk_eq("acc_cnt", 32'(cnt_m), 32'(i + 1));
            chk_eq("acc_ovld", 32'(out_valid_m), (i + 1 == n) ? 1 : 0);
        end
        e_acc = exp_acc(total, aw);
        e_ovf = (total >= (longint'(1) << aw));
        chk_eq("hold_acc", acc_m, 32'(e_acc));
        chk_eq("hold_ovf", 32'(ovf_m), 32'(e_ovf));
        chk_eq("hold_rdy", 32'(in_ready_m), 0);
        for (int h = 0; h < hold_cyc; h++) begin
            in_valid = 1'b1; sum_in = 5'($urandom); out_ready = 1'b0;
            tick();
            chk_eq("stall_acc", acc_m, 32'(e_acc));
            chk_eq("stall_ovf", 32'(ovf_m), 32'(e_ovf));
            chk_eq("stall_ovld", 32'(out_valid_m), 1);
            chk_eq("stall_rdy", 32'(in_ready_m), 0);
            chk_eq("stall_cnt", 32'(cnt_m), 32'(n));
        end
        in_valid = 1'b1; sum_in = 5'($urandom); out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk_eq("hs_ovld", 32'(out_valid_m), 0);
        chk_eq("hs_cnt", 32'(cnt_m), 0);
        chk_eq("hs_ovf", 32'(ovf_m), 0);
        chk_eq("hs_rdy", 32'(in_ready_m), 1);
    endtask

    task automatic fill(input int n, input int unsigned v);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back($urandom_range(0, 31));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sum_in = '0;
        @(negedge clk);
        do_reset();

        // Eight samples of 31: total 248, no overflow in 16 bits.
        fill(8, 31);
        run_frame(0, 0);

        // Mixed samples with idle gaps, then a 5-cycle stall in HOLD.
        smp = '{3, 0, 7, 1, 30, 2, 4, 9};
        run_frame(3, 5);

        for (int f = 0; f < 4; f++) begin
            fill_rand(8);
            run_frame(2, $urandom_range(0, 4));
        end

        // Narrow accumulator: 9 x 31 = 279 overflows 8 bits.
        sel = 1'b1;
        fill(9, 31);
        run_frame(1, 2);
        chk_eq("ovf_next_frame_cnt", 32'(cnt_m), 0);
        fill(9, 1);
        run_frame(0, 1);
        for (int f = 0; f < 4; f++) begin
            fill_rand(9);
            run_frame(2, $urandom_range(0, 3));
        end

        // Reset mid-frame discards the partial total.
        sel = 1'b0;
        for (int i = 0; i < 4; i++) send(20);
        chk_eq("partial_cnt", 32'(cnt_m), 4);
        do_reset();
        fill(8, 1);
        run_frame(0, 0);

        // Reset colliding with the output handshake.
        for (int i = 0; i < 8; i++) send(10);
        chk_eq("pre_rst_ovld", 32'(out_valid_m), 1);
        chk_eq("pre_rst_acc", acc_m, 80);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; sum_in = 5'd7;
        tick();
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk_eq("rsths_acc", acc_m, 0);
        chk_eq("rsths_ovld", 32'(out_valid_m), 0);
        chk_eq("rsths_ovf", 32'(ovf_m), 0);
        chk_eq("rsths_cnt", 32'(cnt_m), 0);
        chk_eq("rsths_rdy", 32'(in_ready_m), 1);
        fill_rand(8);
        run_frame(1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
